// File: rtl/alu_share_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one external 4-op ALU between two requesters. A round-robin arbiter
// picks a requester in IDLE, the operands are presented to the ALU, the result
// is captured after a fixed settle time, and then it is handed back through a
// valid/ready response handshake.
//
// The external ALU only re-evaluates when its op-select S changes. Every
// operation therefore starts with one PRIME cycle that drives S = op ^ 2'b01.
// This forces a change even when two identical ops run back to back.
//
// Sequence: IDLE -> PRIME -> EXEC (SETTLE cycles) -> CAPT -> RESP -> IDLE
//
// Parameters
//   W          operand/result width (must match the ALU)
//   SETTLE     cycles the final S/X/Y are held before capture (1..7)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  [1:0]   request valid per requester
//   req_ready  [1:0]   one-cycle accept pulse, at most one bit set
//   req_op     [3:0]   {op1, op0} ALU op select per requester
//   req_x      [2W-1:0] {x1, x0}
//   req_y      [2W-1:0] {y1, y0}
//   rsp_valid  [1:0]   response valid for the granted requester
//   rsp_ready  [1:0]   requester takes the response
//   rsp_f      [W-1:0] captured ALU F
//   rsp_ovf            captured ALU overflow
//   rsp_cout           captured ALU carry-out
//   alu_x/alu_y        operands to the ALU
//   alu_s      [1:0]   op select to the ALU
//   alu_f/alu_ovf/alu_cout  results from the ALU
//   busy               high in every state except IDLE
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int W      = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op,
    input  logic [2*W-1:0]   req_x,
    input  logic [2*W-1:0]   req_y,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_f,
    output logic             rsp_ovf,
    output logic             rsp_cout,
    output logic [W-1:0]     alu_x,
    output logic [W-1:0]     alu_y,
    output logic [1:0]       alu_s,
    input  logic [W-1:0]     alu_f,
    input  logic             alu_ovf,
    input  logic             alu_cout,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        EXEC  = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // EXEC lasts cnt+1 cycles, so it is loaded with SETTLE-1.
    localparam logic [2:0] CNT_LOAD = 3'(SETTLE - 1);

    state_t         state;
    state_t         state_nxt;
    logic           last_grant;
    logic           grant;
    logic           sel;
    logic           take;
    logic [1:0]     op_q;
    logic [1:0]     op_sel;
    logic [W-1:0]   x_sel;
    logic [W-1:0]   y_sel;
    logic [2:0]     cnt;

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, arbitration and accept pulse
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        take      = 1'b0;

        // On a tie the requester that did not win last time is chosen.
        sel    = (&req_valid) ? ~last_grant : req_valid[1];
        op_sel = sel ? req_op[3:2]    : req_op[1:0];
        x_sel  = sel ? req_x[2*W-1:W] : req_x[W-1:0];
        y_sel  = sel ? req_y[2*W-1:W] : req_y[W-1:0];

        case (state)
            IDLE: begin
                // The accept pulse is suppressed while reset is held so no
                // request is consumed that the controller will not serve.
                if (!rst && (|req_valid)) begin
                    take      = 1'b1;
                    req_ready = sel ? 2'b10 : 2'b01;
                    state_nxt = PRIME;
                end
            end
            PRIME: state_nxt = EXEC;
            EXEC: begin
                if (cnt == 3'd0) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: state_nxt = RESP;
            RESP: begin
                // Only the granted requester's ready bit completes the response.
                if (rsp_ready[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand latch, ALU drive, settle counter, result capture and response
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            op_q       <= 2'b00;
            cnt        <= 3'd0;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_s      <= 2'b00;
            rsp_valid  <= 2'b00;
            rsp_f      <= '0;
            rsp_ovf    <= 1'b0;
            rsp_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        grant      <= sel;
                        last_grant <= sel;
                        op_q       <= op_sel;
                        // Operands go straight to the ALU registers; they are
                        // held unchanged until the next grant.
                        alu_x      <= x_sel;
                        alu_y      <= y_sel;
                        // PRIME select differs from the real op in bit 0.
                        alu_s      <= op_sel ^ 2'b01;
                    end
                end
                PRIME: begin
                    alu_s <= op_q;
                    cnt   <= CNT_LOAD;
                end
                EXEC: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end
                end
                CAPT: begin
                    rsp_f     <= alu_f;
                    rsp_ovf   <= alu_ovf;
                    rsp_cout  <= alu_cout;
                    rsp_valid <= grant ? 2'b10 : 2'b01;
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        rsp_valid <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
